hazard_stall_ctrl: RTL
======================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Port list, clock and reset first, given as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
REQ-002 id_valid, in, 1: decode holds a real instruction (0 = bubble/NOP 0x0800).
REQ-003 id_wreg, in, 3: destination register of the decode instruction.
REQ-004 id_regwrite, in, 1: decode instruction writes the register file.
REQ-005 id_halt, in, 1: decode instruction is HALT.
REQ-006 send_nop, in, 1: hazard request from the comparator; 0 = stall decode, 1 = proceed.
REQ-007 br_taken, in, 1: branch/jump resolved taken in execute this cycle.
REQ-008 ex_reg, mem_reg, wb_reg, out, 3 each: destination tags of the EX, MEM and WB stages.
REQ-009 ex_live, mem_live, wb_live, out, 1 each: stage holds a real instruction (1 = real, 0 = bubble).
REQ-010 mem_wr, wb_wr, out, 1 each: register-write flag of the MEM and WB stages.
REQ-011 pc_en, ifid_en, out, 1 each: PC and IF/ID register write enables.
REQ-012 ifid_flush, out, 1: IF/ID is loaded with NOP 0x0800 this cycle.
REQ-013 idex_bubble, out, 1: ID/EX is loaded with a bubble this cycle.
REQ-014 halted, out, 1: pipeline is halted.
REQ-015 stall_cnt, out, 3: consecutive stall cycles, saturating.
REQ-016 stall_err, out, 1: sticky stall-watchdog error.

Function
REQ-017 State machine states SHALL be RUN, STALL, FLUSH and HALT; encoding is free.
REQ-018 Priority each cycle SHALL be: HALT, then br_taken, then send_nop==0, then normal advance.
REQ-019 RUN/STALL with br_taken=1: next state FLUSH; ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1 in that cycle.
REQ-020 RUN/STALL with br_taken=0 and send_nop=0: next state STALL; pc_en=0, ifid_en=0, idex_bubble=1.
REQ-021 RUN/STALL/FLUSH with br_taken=0 and send_nop=1: next state RUN; pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0.
REQ-022 FLUSH lasts exactly one cycle; the next state is then chosen by REQ-019 to REQ-021 with FLUSH treated as RUN.
REQ-023 Control outputs (pc_en, ifid_en, ifid_flush, idex_bubble) SHALL be combinational from state and inputs; tag outputs SHALL be registered.
REQ-024 Tag shift on every clock outside HALT:
- wb_* <= mem_*; mem_* <= ex_*.
- If idex_bubble=1: ex_live=0, ex_reg=0, ex_wr=0.
- Otherwise: ex_live=id_valid, ex_reg=id_wreg, ex_wr=id_regwrite&id_valid.
REQ-025 ex_wr is internal; it propagates to mem_wr and wb_wr.
REQ-026 A HALT tag (id_halt&id_valid, not bubbled) SHALL travel with the EX/MEM/WB tags; when it reaches WB, the next state is HALT.
REQ-027 br_taken in the same cycle the HALT tag is in EX SHALL squash that HALT tag.
REQ-028 HALT: pc_en=0, ifid_en=0, idex_bubble=1, halted=1, tags frozen; exit only by reset.
REQ-029 stall_cnt SHALL increment each STALL-entry cycle per REQ-020, saturate at 7, and clear on any cycle not matching REQ-020.
REQ-030 stall_err SHALL set when stall_cnt transitions 3->4 (a RAW hazard must clear within 3 stall cycles), and stay set until reset.
REQ-031 br_taken and send_nop=0 together: flush wins; stall_cnt clears.

Reset
REQ-032 rst_n=0 SHALL asynchronously force:
- state=RUN.
- All tags 0; all live and wr flags 0.
- stall_cnt=0, stall_err=0, halted=0.
REQ-033 During reset, combinational outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-034 Reset mid-stall or mid-halt SHALL resume at RUN on the first clock after release.

Verification
REQ-035 Advance: id_valid=1, id_wreg=3, id_regwrite=1, send_nop=1 -> ex_reg=3/ex_live=1 after 1 clock; mem_reg=3/mem_wr=1 after 2; wb_reg=3/wb_wr=1 after 3.
REQ-036 Stall: send_nop=0 for 2 cycles -> pc_en=0, ifid_en=0 in both cycles; two bubbles enter EX (ex_live=0); stall_cnt 1 then 2; back to 0 with pc_en=1 when send_nop=1.
REQ-037 Flush priority: br_taken=1 with send_nop=0 -> ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt=0; state FLUSH for one cycle.
REQ-038 Watchdog: send_nop=0 held 5 cycles -> stall_err=1 from the 4th stall cycle on; stall_cnt=5; error stays 1 after send_nop returns to 1.
REQ-039 Halt: HALT in ID with no branch -> halted=1 three clocks later; pc_en stays 0; further id_valid ignored. Repeat with br_taken=1 while HALT is in EX -> halted stays 0.
REQ-040 Async reset: assert rst_n=0 mid-stall between clock edges -> all tags, stall_cnt and stall_err read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: sequences RUN/STALL/FLUSH/HALT, drives the
// PC and IF/ID enables, and carries destination tags through EX/MEM/WB.
module hazard_stall_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [2:0] id_wreg,
   input  logic       id_regwrite,
   input  logic       id_halt,
   input  logic       send_nop,
   input  logic       br_taken,
   output logic [2:0] ex_reg,
   output logic [2:0] mem_reg,
   output logic [2:0] wb_reg,
   output logic       ex_live,
   output logic       mem_live,
   output logic       wb_live,
   output logic       mem_wr,
   output logic       wb_wr,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       halted,
   output logic [2:0] stall_cnt,
   output logic       stall_err
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic       stall_hit;
   logic [2:0] stall_cnt_next;

   // Internal tag bits that never leave the block.
   logic       ex_wr_reg;
   logic       ex_halt_reg;
   logic       mem_halt_reg;

   // Next state and control enables; reset forces the free-running defaults.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_hit   = 1'b0;
      state_next  = state_reg;
      if (rst_n) begin
         if (state_reg == HALT) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_next  = HALT;
         end else begin
            // FLUSH lasts one cycle and then behaves exactly like RUN.
            if (br_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               state_next  = FLUSH;
            end else if (!send_nop) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               stall_hit   = 1'b1;
               state_next  = STALL;
            end else begin
               state_next  = RUN;
            end
            // The HALT tag moving from MEM into WB ends the run.
            if (mem_halt_reg) begin
               state_next = HALT;
            end
         end
      end
   end

   // Saturating count of consecutive stall-entry cycles.
   always_comb begin
      stall_cnt_next = 3'd0;
      if (stall_hit) begin
         stall_cnt_next = (stall_cnt == 3'd7) ? 3'd7 : stall_cnt + 3'd1;
      end
   end

   // State register, stall counter and sticky watchdog error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         stall_cnt <= 3'd0;
         stall_err <= 1'b0;
      end else begin
         state_reg <= state_next;
         stall_cnt <= stall_cnt_next;
         if (stall_hit && stall_cnt == 3'd3) begin
            stall_err <= 1'b1;
         end
      end
   end

   // Tag pipeline: shifts every clock except while halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg       <= 3'd0;
         ex_live      <= 1'b0;
         ex_wr_reg    <= 1'b0;
         ex_halt_reg  <= 1'b0;
         mem_reg      <= 3'd0;
         mem_live     <= 1'b0;
         mem_wr       <= 1'b0;
         mem_halt_reg <= 1'b0;
         wb_reg       <= 3'd0;
         wb_live      <= 1'b0;
         wb_wr        <= 1'b0;
      end else if (state_reg != HALT) begin
         wb_reg       <= mem_reg;
         wb_live      <= mem_live;
         wb_wr        <= mem_wr;
         mem_reg      <= ex_reg;
         mem_live     <= ex_live;
         mem_wr       <= ex_wr_reg;
         // A branch resolving alongside the HALT in EX squashes the HALT.
         mem_halt_reg <= ex_halt_reg & ~br_taken;
         if (idex_bubble) begin
            ex_reg      <= 3'd0;
            ex_live     <= 1'b0;
            ex_wr_reg   <= 1'b0;
            ex_halt_reg <= 1'b0;
         end else begin
            ex_reg      <= id_wreg;
            ex_live     <= id_valid;
            ex_wr_reg   <= id_regwrite & id_valid;
            ex_halt_reg <= id_halt & id_valid;
         end
      end
   end

   assign halted = (state_reg == HALT);

endmodule
